// File: rtl/fpu_unit.sv
// Multi-cycle binary32 FPU: add/sub/mul/div with RNE rounding and gradual underflow.
package pa_fpu;
  typedef enum logic [1:0] {
    op_add = 2'd0,
    op_sub = 2'd1,
    op_mul = 2'd2,
    op_div = 2'd3
  } e_fpu_op;
endpackage

module fpu_unit
  import pa_fpu::*;
(
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic [1:0]  operation,
  output logic [31:0] ieee_packet_out,
  output logic        cmd_end,
  output logic        busy
);

  localparam int unsigned EXP_W   = 11;
  localparam int unsigned MAN_W   = 28;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [30:0] INF_MAG = 31'h7F800000;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_UNPACK, S_EXEC, S_NORM, S_ROUND, S_DONE, S_RELEASE
  } state_t;

  state_t                    state_q, state_d;
  logic [31:0]               a_q, a_d, b_q, b_d, pkt_q, pkt_d;
  e_fpu_op                   op_q, op_d;
  logic                      cmd_end_q, cmd_end_d, busy_q, busy_d;
  logic                      sign_q, sign_d, sa_q, sa_d, sb_q, sb_d;
  logic signed [EXP_W-1:0]   ea_q, ea_d, eb_q, eb_d, exp_q, exp_d;
  logic [23:0]               ma_q, ma_d, mb_q, mb_d;
  logic [MAN_W-1:0]          man_q, man_d;
  logic [47:0]               prod_q, prod_d, mcand_q, mcand_d;
  logic [25:0]               rem_q, rem_d, quo_q, quo_d;
  logic [4:0]                cnt_q, cnt_d;

  // Right shift keeping every shifted-out bit as sticky in bit 0
  function automatic logic [MAN_W-1:0] shr_sticky(input logic [MAN_W-1:0] x, input logic [7:0] sh);
    logic [MAN_W-1:0] r;
    logic [MAN_W-1:0] mask;
    if (sh >= 8'd28) begin
      r = {27'd0, |x};
    end else begin
      mask = (28'd1 << sh) - 28'd1;
      r    = x >> sh;
      r[0] = r[0] | (|(x & mask));
    end
    return r;
  endfunction

  // Leading zero count over a 27-bit field (27 when all zero)
  function automatic logic [4:0] lzc27(input logic [26:0] x);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && x[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Leading zero count over a 24-bit significand
  function automatic logic [4:0] lzc24(input logic [23:0] x);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && x[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Operand classification, prenormalisation and special-case resolution
  logic                    a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, u_sa, u_sb, u_sx;
  logic [23:0]             a_man, b_man, a_man_n, b_man_n;
  logic signed [EXP_W-1:0] a_exp, b_exp, a_exp_n, b_exp_n;
  logic [4:0]              a_lz, b_lz;
  logic                    spec_hit;
  logic [31:0]             spec_val;

  always_comb begin
    a_zero  = (a_q[30:23] == 8'd0) && (a_q[22:0] == 23'd0);
    b_zero  = (b_q[30:23] == 8'd0) && (b_q[22:0] == 23'd0);
    a_inf   = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf   = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    a_nan   = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan   = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    a_man   = {|a_q[30:23], a_q[22:0]};
    b_man   = {|b_q[30:23], b_q[22:0]};
    a_exp   = (a_q[30:23] == 8'd0) ? 11'sd1 : $signed({3'b000, a_q[30:23]});
    b_exp   = (b_q[30:23] == 8'd0) ? 11'sd1 : $signed({3'b000, b_q[30:23]});
    a_lz    = lzc24(a_man);
    b_lz    = lzc24(b_man);
    a_man_n = a_man << a_lz;
    b_man_n = b_man << b_lz;
    a_exp_n = a_exp - $signed({6'd0, a_lz});
    b_exp_n = b_exp - $signed({6'd0, b_lz});
    u_sa    = a_q[31];
    u_sb    = (op_q == op_sub) ? ~b_q[31] : b_q[31];
    u_sx    = a_q[31] ^ b_q[31];

    spec_hit = 1'b0;
    spec_val = 32'd0;
    if (a_nan || b_nan) begin
      spec_hit = 1'b1;
      spec_val = QNAN;
    end else begin
      case (op_q)
        op_add, op_sub: begin
          if (a_inf && b_inf && (u_sa != u_sb)) begin
            spec_hit = 1'b1; spec_val = QNAN;
          end else if (a_inf) begin
            spec_hit = 1'b1; spec_val = {u_sa, INF_MAG};
          end else if (b_inf) begin
            spec_hit = 1'b1; spec_val = {u_sb, INF_MAG};
          end
        end
        op_mul: begin
          if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_hit = 1'b1; spec_val = QNAN;
          end else if (a_inf || b_inf) begin
            spec_hit = 1'b1; spec_val = {u_sx, INF_MAG};
          end else if (a_zero || b_zero) begin
            spec_hit = 1'b1; spec_val = {u_sx, 31'd0};
          end
        end
        default: begin
          if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_hit = 1'b1; spec_val = QNAN;
          end else if (a_inf || b_zero) begin
            spec_hit = 1'b1; spec_val = {u_sx, INF_MAG};
          end else if (b_inf || a_zero) begin
            spec_hit = 1'b1; spec_val = {u_sx, 31'd0};
          end
        end
      endcase
    end
  end

  // Add/sub: align the smaller operand with sticky, then add or subtract magnitudes
  logic                    ad_a_ge, ad_eff_sub, ad_sign;
  logic signed [EXP_W-1:0] ad_ebig, ad_diff;
  logic [MAN_W-1:0]        ad_mbig, ad_msm, ad_msm_al, ad_sum;
  logic [7:0]              ad_sh;

  always_comb begin
    ad_a_ge    = (ea_q > eb_q) || ((ea_q == eb_q) && (ma_q >= mb_q));
    ad_ebig    = ad_a_ge ? ea_q : eb_q;
    ad_diff    = ad_a_ge ? (ea_q - eb_q) : (eb_q - ea_q);
    ad_mbig    = ad_a_ge ? {1'b0, ma_q, 3'b000} : {1'b0, mb_q, 3'b000};
    ad_msm     = ad_a_ge ? {1'b0, mb_q, 3'b000} : {1'b0, ma_q, 3'b000};
    ad_sh      = (ad_diff > 11'sd255) ? 8'd255 : 8'(ad_diff);
    ad_msm_al  = shr_sticky(ad_msm, ad_sh);
    ad_eff_sub = sa_q != sb_q;
    ad_sum     = ad_eff_sub ? (ad_mbig - ad_msm_al) : (ad_mbig + ad_msm_al);
    if (!ad_eff_sub)            ad_sign = sa_q;
    else if (ad_sum == 28'd0)   ad_sign = 1'b0;
    else                        ad_sign = ad_a_ge ? sa_q : sb_q;
  end

  // One shift-add multiply step and one restoring divide step per cycle
  logic [47:0]      mul_nx;
  logic [MAN_W-1:0] mul_man, div_man;
  logic             div_ge;
  logic [25:0]      div_r;
  logic [26:0]      quo_nx;

  always_comb begin
    mul_nx  = prod_q + (mb_q[0] ? mcand_q : 48'd0);
    mul_man = {mul_nx[47:21], mul_nx[20] | (|mul_nx[19:0])};
    div_ge  = rem_q >= {2'b00, mb_q};
    div_r   = div_ge ? (rem_q - {2'b00, mb_q}) : rem_q;
    quo_nx  = {quo_q, div_ge};
    div_man = {1'b0, quo_nx[26:1], quo_nx[0] | (div_r != 26'd0)};
  end

  // Normalise: carry fix, leading-zero left shift floored at exp 1, or denormalise tiny results
  logic [MAN_W-1:0]        n_m1, n_m2;
  logic signed [EXP_W-1:0] n_e1, n_e2, n_lim, n_rs;
  logic [4:0]              n_lz, n_shl;
  logic [7:0]              n_shr;

  always_comb begin
    if (man_q[27]) begin
      n_m1 = {1'b0, man_q[27:2], man_q[1] | man_q[0]};
      n_e1 = exp_q + 11'sd1;
    end else begin
      n_m1 = man_q;
      n_e1 = exp_q;
    end
    n_lz  = lzc27(n_m1[26:0]);
    n_lim = n_e1 - 11'sd1;
    n_rs  = 11'sd1 - n_e1;
    n_shl = ($signed({6'd0, n_lz}) < n_lim) ? n_lz : 5'(n_lim);
    n_shr = (n_rs > 11'sd255) ? 8'd255 : 8'(n_rs);
    n_m2  = n_m1;
    n_e2  = n_e1;
    if (n_e1 < 11'sd1) begin
      n_m2 = shr_sticky(n_m1, n_shr);
      n_e2 = 11'sd1;
    end else if (!n_m1[26] && (n_e1 > 11'sd1)) begin
      n_m2 = n_m1 << n_shl;
      n_e2 = n_e1 - $signed({6'd0, n_shl});
    end
  end

  // Round to nearest even and pack, saturating to infinity on overflow
  logic                    r_up, r_hid;
  logic [24:0]             r_sum;
  logic signed [EXP_W-1:0] r_exp;
  logic [22:0]             r_frac;
  logic [31:0]             r_pkt;

  always_comb begin
    r_up  = man_q[2] & (man_q[3] | man_q[1] | man_q[0]);
    r_sum = {1'b0, man_q[26:3]} + 25'(r_up);
    if (r_sum[24]) begin
      r_exp  = exp_q + 11'sd1;
      r_frac = 23'd0;
      r_hid  = 1'b1;
    end else begin
      r_exp  = exp_q;
      r_frac = r_sum[22:0];
      r_hid  = r_sum[23];
    end
    if (r_hid && (r_exp >= 11'sd255)) r_pkt = {sign_q, INF_MAG};
    else                              r_pkt = {sign_q, r_hid ? 8'(r_exp) : 8'd0, r_frac};
  end

  // Sequencer: next-state and datapath register updates
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    pkt_d     = pkt_q;
    cmd_end_d = 1'b0;
    busy_d    = busy_q;
    sign_d    = sign_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    exp_d     = exp_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    man_d     = man_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_operand;
          b_d     = b_operand;
          op_d    = e_fpu_op'(operation);
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_UNPACK;
      S_UNPACK: begin
        if (spec_hit) begin
          pkt_d     = spec_val;
          cmd_end_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          sa_d    = u_sa;
          sb_d    = u_sb;
          sign_d  = u_sx;
          cnt_d   = 5'd0;
          prod_d  = 48'd0;
          quo_d   = 26'd0;
          state_d = S_EXEC;
          case (op_q)
            op_mul: begin
              mcand_d = {24'd0, a_man_n};
              mb_d    = b_man_n;
              exp_d   = a_exp_n + b_exp_n - 11'sd127;
            end
            op_div: begin
              rem_d = {2'b00, a_man_n};
              mb_d  = b_man_n;
              exp_d = a_exp_n - b_exp_n + 11'sd127;
            end
            default: begin
              ma_d = a_man;
              mb_d = b_man;
              ea_d = a_exp;
              eb_d = b_exp;
            end
          endcase
        end
      end
      S_EXEC: begin
        case (op_q)
          op_mul: begin
            prod_d  = mul_nx;
            mcand_d = mcand_q << 1;
            mb_d    = mb_q >> 1;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              man_d   = mul_man;
              state_d = S_NORM;
            end
          end
          op_div: begin
            rem_d = {div_r[24:0], 1'b0};
            quo_d = quo_nx[25:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd26) begin
              man_d   = div_man;
              state_d = S_NORM;
            end
          end
          default: begin
            man_d   = ad_sum;
            exp_d   = ad_ebig;
            sign_d  = ad_sign;
            state_d = S_NORM;
          end
        endcase
      end
      S_NORM: begin
        man_d   = n_m2;
        exp_d   = n_e2;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        pkt_d     = r_pkt;
        cmd_end_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_DONE;
      end
      S_DONE:    state_d = S_RELEASE;
      S_RELEASE: if (!start) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q   <= S_IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      op_q      <= op_add;
      pkt_q     <= 32'd0;
      cmd_end_q <= 1'b0;
      busy_q    <= 1'b0;
      sign_q    <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      ea_q      <= '0;
      eb_q      <= '0;
      exp_q     <= '0;
      ma_q      <= 24'd0;
      mb_q      <= 24'd0;
      man_q     <= '0;
      prod_q    <= 48'd0;
      mcand_q   <= 48'd0;
      rem_q     <= 26'd0;
      quo_q     <= 26'd0;
      cnt_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      pkt_q     <= pkt_d;
      cmd_end_q <= cmd_end_d;
      busy_q    <= busy_d;
      sign_q    <= sign_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      exp_q     <= exp_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      man_q     <= man_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ieee_packet_out = pkt_q;
  assign cmd_end         = cmd_end_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_fpu_unit.sv
// Scoreboard bench for fpu_unit: driver queues expected results, monitor checks each cmd_end.
module tb_fpu_unit;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic [31:0] a_operand, b_operand;
  logic [1:0]  operation;
  logic [31:0] ieee_packet_out;
  logic        cmd_end, busy;

  int          total = 0;
  int          bad   = 0;
  int          ce_count = 0;
  logic        prev_ce = 1'b0;
  logic [31:0] exp_fifo[$];
  logic [31:0] mon_e;

  fpu_unit dut (
    .clk            (clk),
    .arst           (arst),
    .start          (start),
    .a_operand      (a_operand),
    .b_operand      (b_operand),
    .operation      (operation),
    .ieee_packet_out(ieee_packet_out),
    .cmd_end        (cmd_end),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  // Monitor: every completion pulse pops one expected result
  always @(negedge clk) begin
    if (arst === 1'b1 && cmd_end === 1'b1) begin
      ce_count++;
      total++;
      if (exp_fifo.size() == 0) begin
        bad++;
        $display("FAIL unexpected_cmd_end got=%h expected=none", ieee_packet_out);
      end else begin
        mon_e = exp_fifo.pop_front();
        if (ieee_packet_out !== mon_e) begin
          bad++;
          $display("FAIL result got=%h expected=%h", ieee_packet_out, mon_e);
        end
      end
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL busy_at_cmd_end got=%b expected=0", busy);
      end
      total++;
      if (prev_ce !== 1'b0) begin
        bad++;
        $display("FAIL cmd_end_width got=multi-cycle expected=one cycle");
      end
    end
    prev_ce = cmd_end;
  end

  // Issue one command, scramble inputs while busy, wait for completion, optionally hold start
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] expv, input int max_lat, input bit hold);
    int cyc;
    int n0;
    exp_fifo.push_back(expv);
    @(negedge clk);
    a_operand = a;
    b_operand = b;
    operation = op;
    start     = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_accept", 32'(busy), 32'd1);
    a_operand = $urandom;
    b_operand = $urandom;
    operation = ~op;
    cyc = 0;
    while (cmd_end !== 1'b1 && cyc <= 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (cmd_end !== 1'b1) begin
      bad++;
      $display("FAIL timeout got=no cmd_end expected=cmd_end within %0d", max_lat);
      if (exp_fifo.size() > 0) void'(exp_fifo.pop_back());
    end else if (cyc > max_lat) begin
      bad++;
      $display("FAIL latency got=%0d expected<=%0d", cyc, max_lat);
    end
    @(negedge clk);
    if (hold) begin
      @(posedge clk);
      n0 = ce_count;
      repeat (10) @(posedge clk);
      #1;
      chk("held_start_no_retrigger", 32'(ce_count), 32'(n0));
      chk("held_start_busy_low", 32'(busy), 32'd0);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    arst      = 1'b0;
    start     = 1'b0;
    a_operand = 32'd0;
    b_operand = 32'd0;
    operation = OP_ADD;
    repeat (3) @(negedge clk);
    chk("reset_out", ieee_packet_out, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cmd_end", 32'(cmd_end), 32'd0);
    arst = 1'b1;
    repeat (2) @(negedge clk);

    run_op(32'h3F800000, 32'h3F8CCCCD, OP_SUB, 32'hBDCCCCD0, 8, 1'b0);
    run_op(32'h41800000, 32'h42000000, OP_ADD, 32'h42400000, 8, 1'b0);
    run_op(32'h00555555, 32'h00555555, OP_ADD, 32'h00AAAAAA, 8, 1'b0);
    run_op(32'h3E800000, 32'h3F000000, OP_MUL, 32'h3E000000, 40, 1'b0);
    run_op(32'h3F800000, 32'h00000000, OP_DIV, 32'h7F800000, 8, 1'b0);
    run_op(32'h00000000, 32'h00000000, OP_DIV, 32'h7FC00000, 8, 1'b0);
    run_op(32'h7F800000, 32'h7F800000, OP_SUB, 32'h7FC00000, 8, 1'b0);
    run_op(32'h7FC00000, 32'h402DF854, OP_ADD, 32'h7FC00000, 8, 1'b0);
    run_op(32'hFF800000, 32'h41200000, OP_SUB, 32'hFF800000, 8, 1'b1);
    run_op(32'h3F800000, 32'h3F800000, OP_SUB, 32'h00000000, 8, 1'b0);
    run_op(32'h80000000, 32'h80000000, OP_ADD, 32'h80000000, 8, 1'b0);
    run_op(32'h4B800000, 32'h3F800000, OP_ADD, 32'h4B800000, 8, 1'b0);
    run_op(32'h4B800000, 32'h40000000, OP_ADD, 32'h4B800001, 8, 1'b0);
    run_op(32'h3FC00000, 32'h40000000, OP_MUL, 32'h40400000, 40, 1'b0);
    run_op(32'h00000001, 32'h4B000000, OP_MUL, 32'h00800000, 40, 1'b0);
    run_op(32'h00800000, 32'h3F000000, OP_MUL, 32'h00400000, 40, 1'b0);
    run_op(32'h00000001, 32'h3F000000, OP_MUL, 32'h00000000, 40, 1'b0);
    run_op(32'h00000001, 32'h3F400000, OP_MUL, 32'h00000001, 40, 1'b0);
    run_op(32'h7F7FFFFF, 32'h40000000, OP_MUL, 32'h7F800000, 40, 1'b0);
    run_op(32'h7F800000, 32'h00000000, OP_MUL, 32'h7FC00000, 8, 1'b0);
    run_op(32'h3F800000, 32'h40400000, OP_DIV, 32'h3EAAAAAB, 40, 1'b0);
    run_op(32'hC0000000, 32'h7F800000, OP_DIV, 32'h80000000, 8, 1'b0);
    run_op(32'h40400000, 32'h3F000000, OP_DIV, 32'h40C00000, 40, 1'b0);

    // Abort a multiply with reset: no completion, outputs cleared
    @(negedge clk);
    a_operand = 32'h3FC00000;
    b_operand = 32'h40000000;
    operation = OP_MUL;
    start     = 1'b1;
    repeat (10) @(negedge clk);
    chk("busy_mid_mul", 32'(busy), 32'd1);
    arst = 1'b0;
    #1;
    chk("abort_out", ieee_packet_out, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cmd_end", 32'(cmd_end), 32'd0);
    start = 1'b0;
    @(negedge clk);
    arst = 1'b1;
    repeat (50) @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    run_op(32'h41800000, 32'h42000000, OP_ADD, 32'h42400000, 8, 1'b0);

    total++;
    if (exp_fifo.size() != 0) begin
      bad++;
      $display("FAIL pending_results got=%0d expected=0", exp_fifo.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
